axi_grid_mni_id_map: RTL and testbench
======================================

# axi_grid_mni_id_map

Transaction-ID remap table for the grid manager network interface (MNI). Each grid request leaving the MNI on its AXI manager port is given a local AXI ID slot. The slot records the requesting source grid node and its original transaction ID. When the subordinate's B/R response returns with that local ID, the block looks up the slot and produces the grid destination and original ID for the returning response flit, then frees the slot on the final beat.

## Interface
Parameters:
- NUM_SLOTS, 8: table depth, i.e. maximum outstanding transactions; power of two, at least 2.
- GRID_ID_W, 4: width of the source grid node ID.
- TXN_ID_W, 4: width of the original transaction ID.
- LOCAL_ID_W, $clog2(NUM_SLOTS): width of the local AXI ID (derived; not overridden).

Ports:
- clk_i  in  1  clock.
- arst_ni  in  1  asynchronous active-low reset.
- alloc_valid_i  in  1  MNI requests a slot.
- alloc_ready_o  out  1  a free slot exists.
- alloc_src_i  in  GRID_ID_W  source grid node to store.
- alloc_id_i  in  TXN_ID_W  original transaction ID to store.
- alloc_local_id_o  out  LOCAL_ID_W  granted slot index; drives AXI AWID/ARID.
- rsp_valid_i  in  1  subordinate response beat present.
- rsp_ready_o  out  1  lookup stage can accept.
- rsp_local_id_i  in  LOCAL_ID_W  BID/RID of the beat.
- rsp_last_i  in  1  final beat (B: tie 1; R: RLAST).
- rsp_valid_o  out  1  lookup result valid.
- rsp_ready_i  in  1  grid side accepts the result.
- rsp_src_o  out  GRID_ID_W  destination grid node for the response flit.
- rsp_id_o  out  TXN_ID_W  original transaction ID.
- rsp_last_o  out  1  registered copy of rsp_last_i.
- outstanding_o  out  LOCAL_ID_W+1  count of busy slots.
- err_o  out  1  sticky protocol error (see Configuration).

## Operation
- State:
  - busy[NUM_SLOTS] bit vector.
  - src/id storage per slot.
  - one output register stage {valid, src, id, last}.
- Allocation:
  - alloc_ready_o = |~busy.
  - alloc_local_id_o = lowest-index free slot (combinational).
  - Handshake (alloc_valid_i & alloc_ready_o): sets busy and writes src/id on the clock edge.
- Lookup:
  - rsp_ready_o = ~rsp_valid_o | rsp_ready_i.
  - On handshake, the output register loads the slot's src/id and rsp_last_i.
  - If rsp_last_i=1, the slot's busy bit clears on the same edge.
- Output hold: rsp_src_o, rsp_id_o and rsp_last_o stay stable while rsp_valid_o & ~rsp_ready_i.
- Counter: outstanding_o += alloc handshake, -= last-beat handshake. Both in the same cycle leaves it unchanged.
- Simultaneous alloc and free of the same slot: allocation sees the pre-edge busy vector, so that slot is not granted this cycle. It becomes grantable the next cycle.
- Full (all busy): alloc_ready_o=0. Lookups still proceed. Freeing one slot raises alloc_ready_o the next cycle.
- Empty: alloc_local_id_o=0. A lookup on a free slot is a protocol error.

## Timing
- Allocation: zero latency.
  - Slot index is valid in the same cycle as alloc_valid_i.
  - Slot reads busy from the next cycle.
- Lookup: one cycle. Beat accepted in cycle N gives rsp_valid_o in cycle N+1.
- Throughput: one lookup per cycle under continuous rsp_ready_i=1.
- No combinational path from rsp_ready_i to storage, apart from rsp_ready_o.
- Reset (asynchronous assert, synchronous-safe deassert), output values:
  - busy=0.
  - rsp_valid_o=0; rsp_src_o, rsp_id_o and rsp_last_o = 0.
  - outstanding_o=0, err_o=0.
  - alloc_ready_o=1, alloc_local_id_o=0, rsp_ready_o=1.
- Reset mid-operation discards all outstanding slots and any pending output beat.

## Configuration
- AXI_GRID_ID_MAP_ERR_CHECK_EN:
  - Defined: a lookup handshake on a slot with busy=0 is accepted but dropped. No output beat is produced, no state changes, and err_o sets and stays 1 until reset.
  - Undefined: err_o is tied 0 and lookups return the slot's stored contents regardless of the busy bit.

## Test plan
- Reset, then 8 allocs (src=i, id=15-i) -> local IDs 0..7 in order; alloc_ready_o=0 after the 8th; outstanding_o=8.
- B beat local_id=3, last=1 while full -> next cycle rsp_src_o=3, rsp_id_o=12, rsp_valid_o=1; alloc_ready_o=1; next alloc gets local ID 3.
- R burst of 4 beats on local_id=5 with rsp_ready_i toggling 1,0,1 -> 4 output beats with src=5, id=10, held stable while stalled; slot 5 freed only on the beat with last=1.
- Same cycle: alloc (2 free, lowest=2) and last-beat free of slot 1 -> grant is 2, not 1; outstanding_o unchanged.
- With ERR_CHECK_EN defined, lookup of free slot 6 -> no rsp_valid_o, err_o=1 sticky; with the macro undefined, err_o stays 0.
- Reset asserted with 4 busy slots and rsp_valid_o=1 -> all outputs return to their reset values immediately; first alloc after reset gets local ID 0.

Source files
------------

// File: rtl/axi_grid_mni_id_map.sv
// axi_grid_mni_id_map
// Transaction-ID remap table for the grid manager network interface.
// Outgoing grid requests are parked in a free local AXI ID slot holding the
// source grid node and original transaction ID; returning B/R beats look the
// slot up through one output register stage and free it on the last beat.
// Optional feature macro: AXI_GRID_ID_MAP_ERR_CHECK_EN
//   defined   -> lookups on free slots are dropped and raise a sticky err_o
//   undefined -> err_o tied 0, lookups return stored contents unconditionally
module axi_grid_mni_id_map #(
  parameter int unsigned NUM_SLOTS  = 8,
  parameter int unsigned GRID_ID_W  = 4,
  parameter int unsigned TXN_ID_W   = 4,
  parameter int unsigned LOCAL_ID_W = $clog2(NUM_SLOTS)
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  input  logic [GRID_ID_W-1:0]  alloc_src_i,
  input  logic [TXN_ID_W-1:0]   alloc_id_i,
  output logic [LOCAL_ID_W-1:0] alloc_local_id_o,
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  input  logic [LOCAL_ID_W-1:0] rsp_local_id_i,
  input  logic                  rsp_last_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [GRID_ID_W-1:0]  rsp_src_o,
  output logic [TXN_ID_W-1:0]   rsp_id_o,
  output logic                  rsp_last_o,
  output logic [LOCAL_ID_W:0]   outstanding_o,
  output logic                  err_o
);

  logic [NUM_SLOTS-1:0]  busy_q;
  logic [NUM_SLOTS-1:0]  busy_d;
  logic [GRID_ID_W-1:0]  src_q [NUM_SLOTS];
  logic [TXN_ID_W-1:0]   id_q  [NUM_SLOTS];

  logic                  out_valid_q;
  logic [GRID_ID_W-1:0]  out_src_q;
  logic [TXN_ID_W-1:0]   out_id_q;
  logic                  out_last_q;
  logic [LOCAL_ID_W:0]   cnt_q;

  logic                  free_found;
  logic [LOCAL_ID_W-1:0] free_idx;
  logic                  alloc_hs;
  logic                  rsp_hs;
  logic                  slot_ok;
  logic                  load_out;
  logic                  free_hs;

  // Lowest-index free slot; index stays 0 when the table is full
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = LOCAL_ID_W'(i);
      end
    end
  end

  assign alloc_ready_o    = free_found;
  assign alloc_local_id_o = free_idx;
  assign alloc_hs         = alloc_valid_i & free_found;

  assign rsp_ready_o = ~out_valid_q | rsp_ready_i;
  assign rsp_hs      = rsp_valid_i & rsp_ready_o;

`ifdef AXI_GRID_ID_MAP_ERR_CHECK_EN
  logic err_q;

  assign slot_ok = busy_q[rsp_local_id_i];
  assign err_o   = err_q;

  // Sticky error on any lookup handshake that hits a free slot
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      err_q <= 1'b0;
    end else if (rsp_hs && !slot_ok) begin
      err_q <= 1'b1;
    end
  end
`else
  assign slot_ok = 1'b1;
  assign err_o   = 1'b0;
`endif

  assign load_out = rsp_hs & slot_ok;
  // Only a genuinely busy slot decrements the count, so the counter always
  // equals the population of the busy vector even for bogus lookups.
  assign free_hs  = load_out & rsp_last_i & busy_q[rsp_local_id_i];

  // Next busy vector: free first, then allocate; the granted slot was chosen
  // from the pre-edge vector, so it can never be the slot freed this cycle.
  always_comb begin
    busy_d = busy_q;
    if (free_hs) begin
      busy_d[rsp_local_id_i] = 1'b0;
    end
    if (alloc_hs) begin
      busy_d[free_idx] = 1'b1;
    end
  end

  // Busy vector and per-slot source/ID storage
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      busy_q <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        src_q[i] <= '0;
        id_q[i]  <= '0;
      end
    end else begin
      busy_q <= busy_d;
      if (alloc_hs) begin
        src_q[free_idx] <= alloc_src_i;
        id_q[free_idx]  <= alloc_id_i;
      end
    end
  end

  // Output register stage; payload holds while the grid side stalls
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      out_src_q   <= src_q[rsp_local_id_i];
      out_id_q    <= id_q[rsp_local_id_i];
      out_last_q  <= rsp_last_i;
    end else if (rsp_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  // Outstanding-transaction counter
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q <= '0;
    end else begin
      case ({alloc_hs, free_hs})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rsp_valid_o   = out_valid_q;
  assign rsp_src_o     = out_src_q;
  assign rsp_id_o      = out_id_q;
  assign rsp_last_o    = out_last_q;
  assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_axi_grid_mni_id_map.sv
// Self-checking bench for axi_grid_mni_id_map: directed scenarios followed by
// randomized traffic, all compared against a slot-table reference model.
module tb_axi_grid_mni_id_map;

  localparam int NUM = 8;

  logic       clk_i = 1'b0;
  logic       arst_ni = 1'b0;
  logic       alloc_valid_i = 1'b0;
  logic       alloc_ready_o;
  logic [3:0] alloc_src_i = '0;
  logic [3:0] alloc_id_i = '0;
  logic [2:0] alloc_local_id_o;
  logic       rsp_valid_i = 1'b0;
  logic       rsp_ready_o;
  logic [2:0] rsp_local_id_i = '0;
  logic       rsp_last_i = 1'b0;
  logic       rsp_valid_o;
  logic       rsp_ready_i = 1'b0;
  logic [3:0] rsp_src_o;
  logic [3:0] rsp_id_o;
  logic       rsp_last_o;
  logic [3:0] outstanding_o;
  logic       err_o;

  axi_grid_mni_id_map #(
    .NUM_SLOTS (8),
    .GRID_ID_W (4),
    .TXN_ID_W  (4)
  ) dut (
    .clk_i            (clk_i),
    .arst_ni          (arst_ni),
    .alloc_valid_i    (alloc_valid_i),
    .alloc_ready_o    (alloc_ready_o),
    .alloc_src_i      (alloc_src_i),
    .alloc_id_i       (alloc_id_i),
    .alloc_local_id_o (alloc_local_id_o),
    .rsp_valid_i      (rsp_valid_i),
    .rsp_ready_o      (rsp_ready_o),
    .rsp_local_id_i   (rsp_local_id_i),
    .rsp_last_i       (rsp_last_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_src_o        (rsp_src_o),
    .rsp_id_o         (rsp_id_o),
    .rsp_last_o       (rsp_last_o),
    .outstanding_o    (outstanding_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: slot table plus the pending output beat
  bit         m_busy [NUM];
  logic [3:0] m_src  [NUM];
  logic [3:0] m_id   [NUM];
  bit         m_valid;
  logic [3:0] m_osrc;
  logic [3:0] m_oid;
  bit         m_olast;
  bit         m_err;
  bit         m_rsp_hs;
  int         obs_lid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NUM; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  function automatic int m_lowest_free();
    for (int i = 0; i < NUM; i++) if (!m_busy[i]) return i;
    return 0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NUM; i++) begin
      m_busy[i] = 1'b0;
      m_src[i]  = '0;
      m_id[i]   = '0;
    end
    m_valid = 1'b0;
    m_osrc  = '0;
    m_oid   = '0;
    m_olast = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic check_regs();
    check_eq("rsp_valid", rsp_valid_o, m_valid);
    check_eq("rsp_src", rsp_src_o, m_osrc);
    check_eq("rsp_id", rsp_id_o, m_oid);
    check_eq("rsp_last", rsp_last_o, m_olast);
    check_eq("outstanding", outstanding_o, m_count());
    check_eq("err", err_o, m_err);
  endtask

  // One clock cycle: drive, check combinational outputs, clock, update model,
  // check registered outputs. Entered and left at posedge + 1.
  task automatic cycle(input bit av, input logic [3:0] asrc, input logic [3:0] aid,
                       input bit rv, input logic [2:0] lid, input bit last, input bit rrdy);
    int  g;
    bit  any_free, hs_a, hs_r, ok;
    alloc_valid_i  = av;
    alloc_src_i    = asrc;
    alloc_id_i     = aid;
    rsp_valid_i    = rv;
    rsp_local_id_i = lid;
    rsp_last_i     = last;
    rsp_ready_i    = rrdy;
    #1;
    any_free = (m_count() < NUM);
    g        = m_lowest_free();
    check_eq("alloc_ready", alloc_ready_o, any_free);
    check_eq("alloc_lid", alloc_local_id_o, g);
    check_eq("rsp_ready", rsp_ready_o, !m_valid || rrdy);
    obs_lid = alloc_local_id_o;
    hs_a = av && any_free;
    hs_r = rv && (!m_valid || rrdy);
`ifdef AXI_GRID_ID_MAP_ERR_CHECK_EN
    ok = m_busy[lid];
`else
    ok = 1'b1;
`endif
    @(posedge clk_i);
    #1;
    if (hs_r && ok) begin
      m_valid = 1'b1;
      m_osrc  = m_src[lid];
      m_oid   = m_id[lid];
      m_olast = last;
      if (last) m_busy[lid] = 1'b0;
    end else begin
      if (hs_r) m_err = 1'b1;
      if (rrdy) m_valid = 1'b0;
    end
    if (hs_a) begin
      m_busy[g] = 1'b1;
      m_src[g]  = asrc;
      m_id[g]   = aid;
    end
    m_rsp_hs = hs_r && ok;
    check_regs();
  endtask

  task automatic idle(input bit rrdy);
    cycle(1'b0, 4'd0, 4'd0, 1'b0, 3'd0, 1'b0, rrdy);
  endtask

  // Assert reset asynchronously, check reset values, release between edges
  task automatic reset_dut();
    arst_ni       = 1'b0;
    alloc_valid_i = 1'b0;
    rsp_valid_i   = 1'b0;
    rsp_ready_i   = 1'b0;
    #1;
    check_eq("rst_rsp_valid", rsp_valid_o, 0);
    check_eq("rst_rsp_src", rsp_src_o, 0);
    check_eq("rst_rsp_id", rsp_id_o, 0);
    check_eq("rst_rsp_last", rsp_last_o, 0);
    check_eq("rst_outstanding", outstanding_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_alloc_ready", alloc_ready_o, 1);
    check_eq("rst_alloc_lid", alloc_local_id_o, 0);
    check_eq("rst_rsp_ready", rsp_ready_o, 1);
    m_clear();
    @(posedge clk_i);
    #2;
    arst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int acc;
    int k;
    int q[$];
    bit av, rv, last, rrdy;
    logic [2:0] lid;

    m_clear();
    reset_dut();

    // Fill the table: grants in ascending order
    for (int i = 0; i < NUM; i++) begin
      cycle(1'b1, 4'(i), 4'(15 - i), 1'b0, 3'd0, 1'b0, 1'b1);
      check_eq("fill_lid", obs_lid, i);
    end
    check_eq("full_alloc_ready", alloc_ready_o, 0);
    check_eq("full_outstanding", outstanding_o, 8);

    // B beat on slot 3 while full
    cycle(1'b0, 4'd0, 4'd0, 1'b1, 3'd3, 1'b1, 1'b1);
    check_eq("b_valid", rsp_valid_o, 1);
    check_eq("b_src", rsp_src_o, 3);
    check_eq("b_id", rsp_id_o, 12);
    check_eq("b_alloc_ready", alloc_ready_o, 1);
    cycle(1'b1, 4'd3, 4'd12, 1'b0, 3'd0, 1'b0, 1'b1);
    check_eq("realloc_lid", obs_lid, 3);

    // 4-beat R burst on slot 5 with stalling grid side
    acc = 0;
    k   = 0;
    while (acc < 4 && k < 20) begin
      cycle(1'b0, 4'd0, 4'd0, 1'b1, 3'd5, acc == 3, k % 2 == 0);
      if (m_rsp_hs) acc++;
      if (rsp_valid_o) begin
        check_eq("burst_src", rsp_src_o, 5);
        check_eq("burst_id", rsp_id_o, 10);
      end
      check_eq("burst_slot_free", alloc_ready_o, acc == 4);
      k++;
    end
    check_eq("burst_beats", acc, 4);
    idle(1'b1);

    // Free slot 2, then allocate while freeing slot 1 in the same cycle
    cycle(1'b0, 4'd0, 4'd0, 1'b1, 3'd2, 1'b1, 1'b1);
    check_eq("pre_same_outstanding", outstanding_o, 6);
    cycle(1'b1, 4'd9, 4'd9, 1'b1, 3'd1, 1'b1, 1'b1);
    check_eq("same_cycle_lid", obs_lid, 2);
    check_eq("same_cycle_outstanding", outstanding_o, 6);
    idle(1'b1);
    check_eq("freed_grantable", obs_lid, 1);

    // Lookup of a free slot
    cycle(1'b0, 4'd0, 4'd0, 1'b1, 3'd6, 1'b1, 1'b1);
    cycle(1'b0, 4'd0, 4'd0, 1'b1, 3'd6, 1'b1, 1'b1);
`ifdef AXI_GRID_ID_MAP_ERR_CHECK_EN
    check_eq("badlookup_valid", rsp_valid_o, 0);
    check_eq("badlookup_err", err_o, 1);
    idle(1'b1);
    idle(1'b1);
    check_eq("err_sticky", err_o, 1);
`else
    check_eq("badlookup_valid", rsp_valid_o, 1);
    check_eq("badlookup_err", err_o, 0);
    idle(1'b1);
    check_eq("err_tied", err_o, 0);
`endif

    // Randomized traffic, lookups biased towards busy slots
    for (int n = 0; n < 400; n++) begin
      q.delete();
      for (int i = 0; i < NUM; i++) if (m_busy[i]) q.push_back(i);
      av   = ($urandom_range(0, 99) < 50);
      rv   = ($urandom_range(0, 99) < 60);
      rrdy = ($urandom_range(0, 99) < 70);
      last = ($urandom_range(0, 99) < 40);
      if (q.size() > 0 && $urandom_range(0, 99) < 85)
        lid = 3'(q[$urandom_range(0, q.size() - 1)]);
      else
        lid = 3'($urandom_range(0, NUM - 1));
      cycle(av, 4'($urandom), 4'($urandom), rv, lid, last, rrdy);
    end

    // Reset in the middle of traffic
    reset_dut();
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 4), 4'(i), 1'b0, 3'd0, 1'b0, 1'b1);
    cycle(1'b0, 4'd0, 4'd0, 1'b1, 3'd0, 1'b0, 1'b0);
    check_eq("pre_rst_valid", rsp_valid_o, 1);
    check_eq("pre_rst_outstanding", outstanding_o, 4);
    #3;
    reset_dut();
    cycle(1'b1, 4'd1, 4'd1, 1'b0, 3'd0, 1'b0, 1'b1);
    check_eq("post_rst_lid", obs_lid, 0);
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
